escaner_teclado: RTL

Scanner for a 4x4 matrix keypad. It is the producing end of the keypad interface that fsm_control consumes on teclado_i/key_detect_i.
- Drives the columns and samples the rows.
- Debounces press and release.
- Presents a 4-bit key code plus a one-cycle key_detect_o strobe.
- Sits in top between the keypad pins and fsm_control.

---
 rtl/teclado_pkg.sv | 61 ++++++
 rtl/sincronizador_2ff.sv | 27 ++
 rtl/escaner_teclado.sv | 120 ++++++++++++
 3 files changed

// File: rtl/teclado_pkg.sv
// Shared types and lookup helpers for the 4x4 keypad scanner.
// Rows and columns are active-low; codes follow the printed keypad legend.
package teclado_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } estado_t;

    localparam logic [3:0] COL0 = 4'b1110;
    localparam logic [3:0] COL1 = 4'b1101;
    localparam logic [3:0] COL2 = 4'b1011;
    localparam logic [3:0] COL3 = 4'b0111;

    function automatic logic [3:0] columna_activa(input logic [1:0] col);
        logic [3:0] mascara;
        case (col)
            2'd0:    mascara = COL0;
            2'd1:    mascara = COL1;
            2'd2:    mascara = COL2;
            default: mascara = COL3;
        endcase
        return mascara;
    endfunction

    // '*' and '#' have no hex digit of their own, so they map to E and F.
    function automatic logic [3:0] codigo_tecla(input logic [1:0] fila, input logic [1:0] col);
        logic [3:0] codigo;
        case ({fila, col})
            4'b00_00: codigo = 4'h1;
            4'b00_01: codigo = 4'h2;
            4'b00_10: codigo = 4'h3;
            4'b00_11: codigo = 4'hA;
            4'b01_00: codigo = 4'h4;
            4'b01_01: codigo = 4'h5;
            4'b01_10: codigo = 4'h6;
            4'b01_11: codigo = 4'hB;
            4'b10_00: codigo = 4'h7;
            4'b10_01: codigo = 4'h8;
            4'b10_10: codigo = 4'h9;
            4'b10_11: codigo = 4'hC;
            4'b11_00: codigo = 4'hE;
            4'b11_01: codigo = 4'h0;
            4'b11_10: codigo = 4'hF;
            default:  codigo = 4'hD;
        endcase
        return codigo;
    endfunction

    function automatic logic [1:0] fila_mas_baja(input logic [3:0] filas);
        logic [1:0] indice;
        if (!filas[0])      indice = 2'd0;
        else if (!filas[1]) indice = 2'd1;
        else if (!filas[2]) indice = 2'd2;
        else                indice = 2'd3;
        return indice;
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all ones
// so idle pulled-up lines never look active while coming out of reset.
module sincronizador_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_etapa1;
    logic [WIDTH-1:0] r_etapa2;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_etapa1 <= '1;
            r_etapa2 <= '1;
        end else begin
            r_etapa1 <= d_i;
            r_etapa2 <= r_etapa1;
        end
    end

    assign q_o = r_etapa2;

endmodule

// File: rtl/escaner_teclado.sv
// 4x4 matrix keypad scanner: walks the columns, debounces press and release
// of a single latched key, and emits its code with a one-cycle strobe.
module escaner_teclado
    import teclado_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] filas_i,
    output logic [3:0] columnas_o,
    output logic [3:0] teclado_o,
    output logic       key_detect_o
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] DWELL_MAX = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    w_filas_s;
    logic          w_alguna_baja;
    logic          w_fila_lat_alta;

    estado_t       r_estado;
    logic [SW-1:0] r_dwell;
    logic [DW-1:0] r_deb;
    logic [1:0]    r_col;
    logic [3:0]    r_columnas;
    logic [1:0]    r_fila;
    logic [3:0]    r_teclado;
    logic          r_detect;

    sincronizador_2ff #(
        .WIDTH (4)
    ) u_sinc_filas (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (filas_i),
        .q_o     (w_filas_s)
    );

    assign w_alguna_baja   = (w_filas_s != 4'hF);
    assign w_fila_lat_alta = w_filas_s[r_fila];

    // Only the latched row is watched once a key is found; the column stays
    // frozen until the scan resumes, so other keys cannot disturb tracking.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_estado   <= SCAN;
            r_dwell    <= '0;
            r_deb      <= '0;
            r_col      <= 2'd0;
            r_columnas <= COL0;
            r_fila     <= 2'd0;
            r_teclado  <= 4'h0;
            r_detect   <= 1'b0;
        end else begin
            r_detect <= 1'b0;
            unique case (r_estado)
                SCAN: begin
                    if (r_dwell == DWELL_MAX) begin
                        r_dwell <= '0;
                        if (w_alguna_baja) begin
                            r_fila   <= fila_mas_baja(w_filas_s);
                            r_deb    <= '0;
                            r_estado <= DEBOUNCE;
                        end else begin
                            r_col      <= r_col + 2'd1;
                            r_columnas <= {r_columnas[2:0], r_columnas[3]};
                        end
                    end else begin
                        r_dwell <= r_dwell + SW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (w_fila_lat_alta) begin
                        r_estado   <= SCAN;
                        r_dwell    <= '0;
                        r_col      <= r_col + 2'd1;
                        r_columnas <= {r_columnas[2:0], r_columnas[3]};
                    end else if (r_deb == DEB_MAX) begin
                        r_teclado <= codigo_tecla(r_fila, r_col);
                        r_detect  <= 1'b1;
                        r_deb     <= '0;
                        r_estado  <= HELD;
                    end else begin
                        r_deb <= r_deb + DW'(1);
                    end
                end
                HELD: begin
                    if (w_fila_lat_alta) begin
                        r_deb    <= '0;
                        r_estado <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!w_fila_lat_alta) begin
                        r_estado <= HELD;
                    end else if (r_deb == DEB_MAX) begin
                        r_deb      <= '0;
                        r_dwell    <= '0;
                        r_estado   <= SCAN;
                        r_col      <= r_col + 2'd1;
                        r_columnas <= {r_columnas[2:0], r_columnas[3]};
                    end else begin
                        r_deb <= r_deb + DW'(1);
                    end
                end
                default: r_estado <= SCAN;
            endcase
        end
    end

    assign columnas_o   = r_columnas;
    assign teclado_o    = r_teclado;
    assign key_detect_o = r_detect;

endmodule
